decode_stage: RTL

- RV32I instruction decode stage; sits between fetch and execute and drives the register file's read address ports.
- Accepts one instruction per cycle from fetch (valid/ready) and decodes fields, control flags and the sign-extended immediate.
- Holds the result in a pipeline register that stalls under execute backpressure, inserts a one-cycle bubble on load-use hazards, and flushes on branch redirect.
- The register file reads synchronously, so operand data arrives in the same cycle the decoded instruction is presented to execute.

---
 rtl/decode_stage.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   RV32I instruction decode stage between fetch and execute.
//   Decodes register indices, class flags and the sign-extended immediate of
//   each accepted instruction into a single pipeline register. Drives the
//   register file read ports so that synchronous read data lines up with the
//   held instruction on the following cycle.
//
// Ports
//   clk, reset                    clock, synchronous active-low reset
//   if_valid/if_ready             fetch handshake
//   if_instr, if_pc               instruction word and its PC from fetch
//   flush                         branch redirect, discards held + incoming
//   read_reg_addr_1/2             register file rs1/rs2 read addresses
//   read_data_1/2                 register file read data (1-cycle latency)
//   ex_ready                      execute accepts the id bundle
//   id_valid, id_pc, id_instr     decoded bundle: valid, PC, raw instruction
//   id_rd, id_rs1, id_rs2         raw register index fields
//   id_rs1_data, id_rs2_data      operands (pass-through of read_data_*)
//   id_imm                        sign-extended immediate
//   id_reg_write                  instruction writes a non-zero rd
//   id_is_load/store/branch       instruction class flags
//   id_illegal                    unsupported opcode
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  input  logic            flush,
  output logic [4:0]      read_reg_addr_1,
  output logic [4:0]      read_reg_addr_2,
  input  logic [XLEN-1:0] read_data_1,
  input  logic [XLEN-1:0] read_data_2,
  input  logic            ex_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [XLEN-1:0] id_rs1_data,
  output logic [XLEN-1:0] id_rs2_data,
  output logic [XLEN-1:0] id_imm,
  output logic            id_reg_write,
  output logic            id_is_load,
  output logic            id_is_store,
  output logic            id_is_branch,
  output logic            id_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_X   // unsupported opcode: no operands, zero immediate
  } fmt_e;

  // Combinational decode of the incoming instruction
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  fmt_e        w_fmt;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_branch;
  logic        w_illegal;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_reg_write;
  logic [31:0] w_imm32;
  logic [XLEN-1:0] w_imm;

  // Handshake / hazard
  logic w_load_use;
  logic w_if_ready;
  logic w_accept;
  logic w_advance;

  // Pipeline register
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [4:0]      r_rd;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic            r_use_rs1;
  logic            r_use_rs2;
  logic [XLEN-1:0] r_imm;
  logic            r_reg_write;
  logic            r_is_load;
  logic            r_is_store;
  logic            r_is_branch;
  logic            r_illegal;

  assign w_opcode = if_instr[6:0];
  assign w_rd     = if_instr[11:7];
  assign w_rs1    = if_instr[19:15];
  assign w_rs2    = if_instr[24:20];

  always_comb begin
    w_fmt       = FMT_X;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_illegal   = 1'b0;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: w_fmt = FMT_U;
      OPC_JAL:            w_fmt = FMT_J;
      OPC_JALR, OPC_OPIMM, OPC_FENCE, OPC_SYSTEM:
                          w_fmt = FMT_I;
      OPC_LOAD: begin
        w_fmt     = FMT_I;
        w_is_load = 1'b1;
      end
      OPC_STORE: begin
        w_fmt      = FMT_S;
        w_is_store = 1'b1;
      end
      OPC_BRANCH: begin
        w_fmt       = FMT_B;
        w_is_branch = 1'b1;
      end
      OPC_OP:             w_fmt = FMT_R;
      default:            w_illegal = 1'b1;
    endcase
  end

  assign w_use_rs1   = (w_fmt == FMT_R) || (w_fmt == FMT_I) ||
                       (w_fmt == FMT_S) || (w_fmt == FMT_B);
  assign w_use_rs2   = (w_fmt == FMT_R) || (w_fmt == FMT_S) || (w_fmt == FMT_B);
  assign w_reg_write = !w_illegal && !w_is_store && !w_is_branch && (w_rd != 5'd0);

  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      FMT_I: w_imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
      FMT_S: w_imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      FMT_B: w_imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                        if_instr[30:25], if_instr[11:8], 1'b0};
      FMT_U: w_imm32 = {if_instr[31:12], 12'b0};
      FMT_J: w_imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                        if_instr[20], if_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));

  // A held load whose result the incoming instruction needs: its data is not
  // available until the load leaves execute, so hold fetch for one cycle.
  assign w_load_use = r_valid && r_is_load && (r_rd != 5'd0) &&
                      ((w_use_rs1 && (w_rs1 == r_rd)) ||
                       (w_use_rs2 && (w_rs2 == r_rd)));

  assign w_if_ready = reset && (!r_valid || ex_ready) && !w_load_use && !flush;
  assign w_accept   = if_valid && w_if_ready;
  assign w_advance  = r_valid && ex_ready;

  // Re-reading the held indices every stall cycle keeps the synchronous read
  // data aligned with the held instruction and picks up writebacks.
  always_comb begin
    if (w_accept) begin
      read_reg_addr_1 = w_use_rs1 ? w_rs1 : 5'd0;
      read_reg_addr_2 = w_use_rs2 ? w_rs2 : 5'd0;
    end else begin
      read_reg_addr_1 = r_use_rs1 ? r_rs1 : 5'd0;
      read_reg_addr_2 = r_use_rs2 ? r_rs2 : 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_instr     <= NOP_INSTR;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_use_rs1   <= 1'b0;
      r_use_rs2   <= 1'b0;
      r_imm       <= '0;
      r_reg_write <= 1'b0;
      r_is_load   <= 1'b0;
      r_is_store  <= 1'b0;
      r_is_branch <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_pc        <= if_pc;
      r_instr     <= if_instr;
      r_rd        <= w_rd;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_use_rs1   <= w_use_rs1;
      r_use_rs2   <= w_use_rs2;
      r_imm       <= w_imm;
      r_reg_write <= w_reg_write;
      r_is_load   <= w_is_load;
      r_is_store  <= w_is_store;
      r_is_branch <= w_is_branch;
      r_illegal   <= w_illegal;
    end else if (w_advance) begin
      r_valid <= 1'b0;
    end
  end

  assign if_ready     = w_if_ready;
  assign id_valid     = r_valid;
  assign id_pc        = r_pc;
  assign id_instr     = r_instr;
  assign id_rd        = r_rd;
  assign id_rs1       = r_rs1;
  assign id_rs2       = r_rs2;
  assign id_rs1_data  = read_data_1;
  assign id_rs2_data  = read_data_2;
  assign id_imm       = r_imm;
  assign id_reg_write = r_reg_write;
  assign id_is_load   = r_is_load;
  assign id_is_store  = r_is_store;
  assign id_is_branch = r_is_branch;
  assign id_illegal   = r_illegal;

endmodule
